// File: rtl/demux_pkg.sv
// Shared channel definitions for the 1:4 demux stage and its feeders.
package demux_pkg;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    typedef logic [CH_W-1:0] ch_sel_t;
endpackage

// File: rtl/demux_credit_dispatch_if.sv
// Upstream stream, credit return and demux drive signals of the credit dispatcher.
interface demux_credit_dispatch_if
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [NUM_CH-1:0] credit_ret;
    logic [DATA_W-1:0] out_data;
    ch_sel_t           out_sel;
    logic              out_valid;
    logic [NUM_CH-1:0] ch_has_credit;
    logic              err_overflow;

    modport master (
        output in_valid, in_data, credit_ret,
        input  in_ready, out_data, out_sel, out_valid, ch_has_credit, err_overflow
    );

    modport slave (
        input  in_valid, in_data, credit_ret,
        output in_ready, out_data, out_sel, out_valid, ch_has_credit, err_overflow
    );
endinterface

// File: rtl/demux_rr_pick.sv
// Combinational round-robin picker: first eligible channel at or after the pointer.
module demux_rr_pick
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] i_elig,
    input  ch_sel_t           i_ptr,
    output ch_sel_t           o_grant,
    output logic              o_any
);
    always_comb begin
        ch_sel_t w_idx;
        o_grant = i_ptr;
        o_any   = 1'b0;
        w_idx   = i_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = i_ptr + ch_sel_t'(k);
            if (!o_any && i_elig[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_credit_dispatch.sv
// Credit-gated round-robin feeder driving the 1:4 demux data/select lines from registers.
module demux_credit_dispatch
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned CREDITS = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    demux_credit_dispatch_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0]  r_credit     [NUM_CH];
    logic [CNT_W-1:0]  w_credit_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_has_credit;
    logic [NUM_CH-1:0] w_consume;
    ch_sel_t           w_grant;
    ch_sel_t           r_rr_ptr;
    ch_sel_t           r_out_sel;
    logic              w_any;
    logic              w_accept;
    logic              w_ovf;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err;

    always_comb begin
        w_has_credit = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_has_credit[n] = (r_credit[n] != '0);
        end
    end

    demux_rr_pick u_pick (
        .i_elig  (w_has_credit),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_accept = bus.in_valid & w_any;

    // Simultaneous consume and return cancel out, even on a full counter.
    always_comb begin
        w_ovf     = 1'b0;
        w_consume = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_credit_nxt[n] = r_credit[n];
            w_consume[n]    = w_accept && (w_grant == ch_sel_t'(n));
            if (w_consume[n] && !bus.credit_ret[n]) begin
                w_credit_nxt[n] = r_credit[n] - 1'b1;
            end else if (bus.credit_ret[n] && !w_consume[n]) begin
                if (r_credit[n] == CRED_MAX) begin
                    w_ovf = 1'b1;
                end else begin
                    w_credit_nxt[n] = r_credit[n] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_credit[n] <= CRED_MAX;
            end
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_err       <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_credit[n] <= w_credit_nxt[n];
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.in_data;
                r_out_sel   <= w_grant;
                r_rr_ptr    <= w_grant + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end
            if (w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready      = w_any;
    assign bus.ch_has_credit = w_has_credit;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_sel       = r_out_sel;
    assign bus.err_overflow  = r_err;
endmodule

// File: tb/tb_demux_credit_dispatch.sv
// Directed and random stimulus checked against a credit/round-robin reference model.
module tb_demux_credit_dispatch;
    localparam int unsigned DW      = 1;
    localparam int          CREDITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_credit_dispatch_if #(.DATA_W(DW)) bus ();

    demux_credit_dispatch #(.DATA_W(DW), .CREDITS(CREDITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;

    // Reference model state
    int   m_cred [4];
    int   m_ptr;
    bit   m_err;
    bit   m_valid;
    int   m_data;
    int   m_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_cred[n] = CREDITS;
        m_ptr = 0; m_err = 0; m_valid = 0; m_data = 0; m_sel = 0;
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] m;
        for (int n = 0; n < 4; n++) m[n] = (m_cred[n] > 0);
        return m;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cyc(input bit r, input bit v, input int d, input logic [3:0] cr);
        bit acc;
        int chan;
        rst            = r;
        bus.in_valid   = v;
        bus.in_data    = DW'(d);
        bus.credit_ret = cr;
        @(negedge clk);
        chk("in_ready", bus.in_ready, (m_mask() != 0));
        chk("ch_has_credit", bus.ch_has_credit, m_mask());
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data", bus.out_data, m_data);
        chk("out_sel", bus.out_sel, m_sel);
        chk("err_overflow", bus.err_overflow, m_err);
        if (bus.out_valid === 1'b1) pulses++;
        if (r) begin
            model_reset();
        end else begin
            acc  = v && (m_mask() != 0);
            chan = -1;
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    if (chan < 0 && m_cred[(m_ptr + k) % 4] > 0) chan = (m_ptr + k) % 4;
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (chan == n && !cr[n]) m_cred[n]--;
                else if (cr[n] && chan != n) begin
                    if (m_cred[n] == CREDITS) m_err = 1;
                    else m_cred[n]++;
                end
            end
            if (acc) begin
                m_valid = 1; m_data = d; m_sel = chan; m_ptr = (chan + 1) % 4;
            end else begin
                m_valid = 0; m_data = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.credit_ret = '0;
        model_reset();
        @(posedge clk); #1;
        cyc(1, 0, 0, 4'b0);

        // Round-robin order 0,1,2,3 with data 1,0,1,1
        cyc(0, 1, 1, 4'b0); cyc(0, 1, 0, 4'b0); cyc(0, 1, 1, 4'b0); cyc(0, 1, 1, 4'b0);
        cyc(0, 0, 0, 4'b0);
        chk("rr_wrap_sel", bus.out_sel, 2'd3);

        // Drain every credit with in_valid held
        cyc(1, 0, 0, 4'b0);
        pulses = 0;
        for (int i = 0; i < 20; i++) cyc(0, 1, i & 1, 4'b0);
        cyc(0, 0, 0, 4'b0);
        chk("drain_pulses", pulses, 16);
        chk("drain_ready", bus.in_ready, 1'b0);
        chk("drain_mask", bus.ch_has_credit, 4'b0000);

        // Single credit back on channel 2
        cyc(0, 0, 0, 4'b0100);
        chk("ret_ready", bus.in_ready, 1'b1);
        cyc(0, 1, 1, 4'b0);
        cyc(0, 0, 0, 4'b0);
        chk("ret_sel", bus.out_sel, 2'd2);
        chk("ret_ready_after", bus.in_ready, 1'b0);

        // Return to a full channel sets the sticky error
        cyc(1, 0, 0, 4'b0);
        cyc(0, 0, 0, 4'b0001);
        cyc(0, 0, 0, 4'b0);
        chk("ovf_set", bus.err_overflow, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b0);

        // Channel 1 at one credit: consume and return together
        cyc(1, 0, 0, 4'b0);
        for (int i = 0; i < 13; i++) cyc(0, 1, 0, 4'b0);
        cyc(0, 1, 1, 4'b0010);
        cyc(0, 0, 0, 4'b0);
        chk("same_cycle_noerr", bus.err_overflow, 1'b0);
        chk("same_cycle_ch1", bus.ch_has_credit[1], 1'b1);

        // Reset while an item is in flight
        cyc(1, 0, 0, 4'b0);
        cyc(0, 1, 1, 4'b0); cyc(0, 1, 1, 4'b0);
        cyc(1, 1, 1, 4'b0);
        chk("rst_flush_valid", bus.out_valid, 1'b0);
        chk("rst_flush_mask", bus.ch_has_credit, 4'b1111);
        cyc(0, 1, 1, 4'b0);
        cyc(0, 0, 0, 4'b0);
        chk("rst_first_sel", bus.out_sel, 2'd0);

        // Random traffic with sparse credit returns and rare resets
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 97) == 0, ($urandom % 4) != 0, int'($urandom % 2),
                4'($urandom & $urandom & $urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
